// File: rtl/pe_ctx_seq_pkg.sv
// Purpose : shared encodings for the context-sequenced PE (opcodes, operand and
//           output selects, instruction field layout, FSM states).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pe_ctx_seq_pkg;

   // Instruction word width; fixed by the field layout below.
   localparam int INST_W = 20;

   // Field LSB positions, MSB->LSB: op, sel_a, sel_b, wr, osel_N/S/W/E.
   localparam int OP_LSB   = 16;
   localparam int SELA_LSB = 13;
   localparam int SELB_LSB = 10;
   localparam int WR_LSB   = 8;
   localparam int OSN_LSB  = 6;
   localparam int OSS_LSB  = 4;
   localparam int OSW_LSB  = 2;
   localparam int OSE_LSB  = 0;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;

   localparam logic [2:0] SEL_N    = 3'd0;
   localparam logic [2:0] SEL_S    = 3'd1;
   localparam logic [2:0] SEL_W    = 3'd2;
   localparam logic [2:0] SEL_E    = 3'd3;
   localparam logic [2:0] SEL_RES  = 3'd4;
   localparam logic [2:0] SEL_R0   = 3'd5;
   localparam logic [2:0] SEL_R1   = 3'd6;
   localparam logic [2:0] SEL_ZERO = 3'd7;

   localparam logic [1:0] OSEL_ZERO = 2'd0;
   localparam logic [1:0] OSEL_RES  = 2'd1;
   localparam logic [1:0] OSEL_OPP  = 2'd2;
   localparam logic [1:0] OSEL_R0   = 2'd3;

   typedef struct packed {
      logic [3:0] op;
      logic [2:0] sel_a;
      logic [2:0] sel_b;
      logic [1:0] wr;
      logic [1:0] osel_n;
      logic [1:0] osel_s;
      logic [1:0] osel_w;
      logic [1:0] osel_e;
   } inst_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/pe_ctx_seq_if.sv
// Purpose : bundles the PE's config stream, run control and neighbour buses.
// Latency : n/a (wiring only).
// Backpr. : cfg_ready is driven by the slave (PE) side.
// Ports   : slave = PE view, master = driver/neighbour view.
interface pe_ctx_seq_if
   import pe_ctx_seq_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int ITW   = 16
) ();
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [INST_W-1:0] cfg_data;
   logic              cfg_last;
   logic              start;
   logic [ITW-1:0]    iter;
   logic              abort;
   logic              stall;
   logic [DW-1:0]     din_N, din_S, din_W, din_E;
   logic [DW-1:0]     dout_N, dout_S, dout_W, dout_E;
   logic              busy;
   logic              done;
   logic [PW-1:0]     ctx_ptr;

   modport slave (
      input  cfg_valid, cfg_data, cfg_last, start, iter, abort, stall,
      input  din_N, din_S, din_W, din_E,
      output cfg_ready, dout_N, dout_S, dout_W, dout_E, busy, done, ctx_ptr
   );

   modport master (
      output cfg_valid, cfg_data, cfg_last, start, iter, abort, stall,
      output din_N, din_S, din_W, din_E,
      input  cfg_ready, dout_N, dout_S, dout_W, dout_E, busy, done, ctx_ptr
   );
endinterface

// File: rtl/pe_ctx_seq_alu.sv
// Purpose : DW-wide unsigned ALU for the PE (mod 2^DW arithmetic).
// Latency : combinational.
// Backpr. : none.
// Ports   : op_i opcode, a_i/b_i operands, res_o result (0 for NOP/unused ops).
module pe_alu
   import pe_ctx_seq_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] res_o
);
   localparam int SW = $clog2(DW);

   // Shifts only look at the low log2(DW) bits of b.
   logic [SW-1:0] sh;
   assign sh = b_i[SW-1:0];

   always_comb begin
      res_o = '0;
      case (op_i)
         OP_ADD:  res_o = a_i + b_i;
         OP_SUB:  res_o = a_i - b_i;
         OP_MUL:  res_o = a_i * b_i;
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_XOR:  res_o = a_i ^ b_i;
         OP_SHL:  res_o = a_i << sh;
         OP_SHR:  res_o = a_i >> sh;
         OP_PASS: res_o = a_i;
         default: res_o = '0;
      endcase
   end
endmodule

// File: rtl/pe_ctx_seq.sv
// Purpose : CGRA PE with a DEPTH-entry context store, replayed cyclically for iter passes.
// Latency : context fetch -> res visible 2 cycles; done one cycle after the drain cycle.
// Backpr. : cfg_ready only in IDLE/LOAD; stall freezes the run, abort ends it.
// Ports   : clk, rst (sync, active-high); io = config stream, run control, neighbour I/O.
module pe_ctx_seq
   import pe_ctx_seq_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int ITW   = 16
) (
   input logic         clk,
   input logic         rst,
   pe_ctx_seq_if.slave io
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   state_e            state_q, state_d;
   logic [PW-1:0]     wptr_q, wptr_d, ptr_q, ptr_d;
   logic [LW-1:0]     len_q, len_d;
   logic [ITW-1:0]    pass_q, pass_d, iter_q, iter_d;
   inst_t             inst_q, inst_d;
   logic              exe_q, exe_d;     // inst_q holds a fetched context
   logic              drain_q, drain_d; // final fetch issued, one execute left
   logic [DW-1:0]     res_q, res_d, r0_q, r0_d, r1_q, r1_d;
   logic [INST_W-1:0] store [DEPTH];

   logic              cfg_acc;
   logic [PW-1:0]     widx;
   logic              ptr_last;
   logic [ITW-1:0]    pass_nxt;
   logic [DW-1:0]     opa, opb, fu_res;

   function automatic logic [DW-1:0] pick(input logic [2:0] s,
                                          input logic [DW-1:0] n, sx, w, e, r, a0, a1);
      case (s)
         SEL_N:   return n;
         SEL_S:   return sx;
         SEL_W:   return w;
         SEL_E:   return e;
         SEL_RES: return r;
         SEL_R0:  return a0;
         SEL_R1:  return a1;
         default: return '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] route(input logic [1:0] o,
                                           input logic [DW-1:0] fu, opp, a0);
      case (o)
         OSEL_ZERO: return '0;
         OSEL_RES:  return fu;
         OSEL_OPP:  return opp;
         default:   return a0;
      endcase
   endfunction

   assign cfg_acc  = io.cfg_valid && io.cfg_ready;
   // A load starting from IDLE always writes entry 0.
   assign widx     = (state_q == ST_IDLE) ? '0 : wptr_q;
   assign ptr_last = (LW'(ptr_q) == len_q - LW'(1));
   assign pass_nxt = pass_q + ITW'(1);

   assign opa = pick(inst_q.sel_a, io.din_N, io.din_S, io.din_W, io.din_E, res_q, r0_q, r1_q);
   assign opb = pick(inst_q.sel_b, io.din_N, io.din_S, io.din_W, io.din_E, res_q, r0_q, r1_q);

   pe_alu #(.DW(DW)) u_alu (
      .op_i  (inst_q.op),
      .a_i   (opa),
      .b_i   (opb),
      .res_o (fu_res)
   );

   always_ff @(posedge clk) begin
      if (cfg_acc) store[widx] <= io.cfg_data;
   end

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      pass_d  = pass_q;
      iter_d  = iter_q;
      inst_d  = inst_q;
      exe_d   = exe_q;
      drain_d = drain_q;
      res_d   = res_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      case (state_q)
         ST_IDLE: begin
            // A config word wins over a simultaneous start.
            if (cfg_acc) begin
               wptr_d = PW'(1);
               if (io.cfg_last) len_d = LW'(1);
               else             state_d = ST_LOAD;
            end else if (io.start && (len_q != '0)) begin
               state_d = ST_RUN;
               ptr_d   = '0;
               pass_d  = '0;
               iter_d  = io.iter;
               exe_d   = 1'b0;
               drain_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (cfg_acc) begin
               wptr_d = wptr_q + PW'(1);
               if (io.cfg_last || (wptr_q == PW'(DEPTH - 1))) begin
                  state_d = ST_IDLE;
                  len_d   = LW'(wptr_q) + LW'(1);
               end
            end
         end
         ST_RUN: begin
            if (io.abort) begin
               state_d = ST_DONE;
               inst_d  = '0;
               exe_d   = 1'b0;
            end else if (!io.stall) begin
               if (exe_q) begin
                  res_d = fu_res;
                  if (inst_q.wr[0]) r0_d = fu_res;
                  if (inst_q.wr[1]) r1_d = fu_res;
               end
               if (drain_q) begin
                  state_d = ST_DONE;
                  inst_d  = '0;
                  exe_d   = 1'b0;
               end else begin
                  inst_d = inst_t'(store[ptr_q]);
                  exe_d  = 1'b1;
                  if (ptr_last) begin
                     ptr_d  = '0;
                     pass_d = pass_nxt;
                     // iter == 0 never matches: run until abort.
                     if ((iter_q != '0) && (pass_nxt == iter_q)) drain_d = 1'b1;
                  end else begin
                     ptr_d = ptr_q + PW'(1);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wptr_q  <= '0;
         ptr_q   <= '0;
         len_q   <= '0;
         pass_q  <= '0;
         iter_q  <= '0;
         inst_q  <= '0;
         exe_q   <= 1'b0;
         drain_q <= 1'b0;
         res_q   <= '0;
         r0_q    <= '0;
         r1_q    <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         pass_q  <= pass_d;
         iter_q  <= iter_d;
         inst_q  <= inst_d;
         exe_q   <= exe_d;
         drain_q <= drain_d;
         res_q   <= res_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
      end
   end

   assign io.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign io.busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign io.done      = (state_q == ST_DONE);
   assign io.ctx_ptr   = ptr_q;
   assign io.dout_N    = route(inst_q.osel_n, fu_res, io.din_S, r0_q);
   assign io.dout_S    = route(inst_q.osel_s, fu_res, io.din_N, r0_q);
   assign io.dout_W    = route(inst_q.osel_w, fu_res, io.din_E, r0_q);
   assign io.dout_E    = route(inst_q.osel_e, fu_res, io.din_W, r0_q);
endmodule

// File: tb/tb_pe_ctx_seq.sv
// Purpose : directed bench for pe_ctx_seq with a per-cycle expected-output scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_pe_ctx_seq;
   import pe_ctx_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_ctx_seq_if #(.DW(32), .DEPTH(16), .ITW(16)) io ();

   pe_ctx_seq #(.DW(32), .DEPTH(16), .ITW(16)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   typedef struct {
      logic [31:0] n, s, w, e;
      logic [3:0]  ptr;
      bit          chk_ptr;
      bit          busy, done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [19:0] mk(input int op, input int sa, input int sb_, input int wr,
                                      input int on, input int os, input int ow, input int oe);
      logic [19:0] w;
      w = '0;
      w[OP_LSB   +: 4] = op[3:0];
      w[SELA_LSB +: 3] = sa[2:0];
      w[SELB_LSB +: 3] = sb_[2:0];
      w[WR_LSB   +: 2] = wr[1:0];
      w[OSN_LSB  +: 2] = on[1:0];
      w[OSS_LSB  +: 2] = os[1:0];
      w[OSW_LSB  +: 2] = ow[1:0];
      w[OSE_LSB  +: 2] = oe[1:0];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] n, input logic [31:0] s, input logic [31:0] w,
                       input logic [31:0] e, input int ptr, input bit cp, input bit busy,
                       input bit done);
      exp_t x;
      x.n = n; x.s = s; x.w = w; x.e = e;
      x.ptr = ptr[3:0]; x.chk_ptr = cp; x.busy = busy; x.done = done;
      sb.push_back(x);
   endtask

   task automatic cmp_sb(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty, observed output with no expectation", tag);
         return;
      end
      x = sb.pop_front();
      chk({tag, ".dout_N"}, io.dout_N, x.n);
      chk({tag, ".dout_S"}, io.dout_S, x.s);
      chk({tag, ".dout_W"}, io.dout_W, x.w);
      chk({tag, ".dout_E"}, io.dout_E, x.e);
      if (x.chk_ptr) chk({tag, ".ctx_ptr"}, 32'(io.ctx_ptr), 32'(x.ptr));
      chk({tag, ".busy"}, 32'(io.busy), 32'(x.busy));
      chk({tag, ".done"}, 32'(io.done), 32'(x.done));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [19:0] w, input bit last, input int gap);
      io.cfg_valid = 1'b1;
      io.cfg_data  = w;
      io.cfg_last  = last;
      #1;
      chk("cfg_ready", 32'(io.cfg_ready), 32'd1);
      step();
      io.cfg_valid = 1'b0;
      io.cfg_last  = 1'b0;
      repeat (gap) step();
   endtask

   // Cycle 0 is the first RUN cycle; stall covers [st_from, st_from+st_len).
   task automatic run_sb(input string tag, input int n, input int st_from, input int st_len,
                         input int ab_at);
      for (int k = 0; k < n; k++) begin
         io.stall = (k >= st_from) && (k < st_from + st_len);
         io.abort = (k == ab_at);
         #1;
         cmp_sb($sformatf("%s.c%0d", tag, k));
         step();
      end
      io.stall = 1'b0;
      io.abort = 1'b0;
   endtask

   task automatic kick(input int it);
      io.iter  = it[15:0];
      io.start = 1'b1;
      step();
      io.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      io.cfg_valid = 1'b0; io.cfg_data = '0; io.cfg_last = 1'b0;
      io.start = 1'b0; io.iter = '0; io.abort = 1'b0; io.stall = 1'b0;
      io.din_N = '0; io.din_S = '0; io.din_W = '0; io.din_E = '0;
      repeat (2) step();
      chk("rst.busy",      32'(io.busy), 0);
      chk("rst.done",      32'(io.done), 0);
      chk("rst.cfg_ready", 32'(io.cfg_ready), 1);
      chk("rst.ctx_ptr",   32'(io.ctx_ptr), 0);
      chk("rst.dout_N",    io.dout_N, 0);
      chk("rst.dout_E",    io.dout_E, 0);
      rst = 1'b0;
      step();

      // Three-word program with valid gaps, two passes.
      send(mk(1, 0, 2, 1, 0, 0, 0, 1), 1'b0, 1);   // ADD N,W -> R0, E=fu
      chk("loadA.busy", 32'(io.busy), 1);
      send(mk(9, 4, 7, 0, 1, 0, 0, 0), 1'b0, 2);   // PASS res, N=fu
      send(mk(2, 5, 0, 0, 0, 2, 1, 3), 1'b1, 0);   // SUB R0,N, S=opp W=fu E=R0
      chk("loadA.idle", 32'(io.busy), 0);
      io.din_N = 32'd5; io.din_W = 32'd7;
      push(0, 0, 0, 0,  0, 1, 1, 0);
      push(0, 0, 0, 12, 1, 1, 1, 0);
      push(12, 0, 0, 0, 2, 1, 1, 0);
      push(0, 5, 7, 12, 0, 1, 1, 0);
      push(0, 0, 0, 12, 1, 1, 1, 0);
      push(12, 0, 0, 0, 2, 1, 1, 0);
      push(0, 5, 7, 12, 0, 1, 1, 0);
      push(0, 0, 0, 0,  0, 1, 0, 1);
      push(0, 0, 0, 0,  0, 1, 0, 0);
      kick(2);
      run_sb("runA", 9, 100, 0, -1);

      // ALU corners, one pass, 4-cycle stall from cycle 2.
      io.din_N = 32'd1; io.din_S = 32'd35; io.din_W = 32'h10000; io.din_E = 32'h10000;
      send(mk(2, 7, 0, 0, 0, 0, 0, 1), 1'b0, 0);   // 0 - 1
      send(mk(7, 0, 1, 0, 0, 0, 0, 1), 1'b0, 0);   // 1 << (35 mod 32)
      send(mk(3, 2, 3, 0, 0, 0, 0, 1), 1'b0, 0);   // 0x10000 * 0x10000
      send(mk(8, 3, 0, 0, 0, 0, 0, 1), 1'b0, 0);   // 0x10000 >> 1
      send(mk(5, 2, 0, 0, 0, 0, 0, 1), 1'b0, 0);   // 0x10000 | 1
      send(mk(4, 1, 0, 0, 0, 0, 0, 1), 1'b0, 0);   // 35 & 1
      send(mk(12, 1, 0, 0, 0, 0, 0, 1), 1'b1, 0);  // reserved op -> 0
      push(0, 0, 0, 0, 0, 1, 1, 0);
      push(0, 0, 0, 32'hFFFF_FFFF, 1, 1, 1, 0);
      for (int k = 0; k < 5; k++) push(0, 0, 0, 8, 2, 1, 1, 0);
      push(0, 0, 0, 0,        3, 1, 1, 0);
      push(0, 0, 0, 32'h8000, 4, 1, 1, 0);
      push(0, 0, 0, 32'h10001, 5, 1, 1, 0);
      push(0, 0, 0, 1,        6, 1, 1, 0);
      push(0, 0, 0, 0,        0, 1, 1, 0);
      push(0, 0, 0, 0,        0, 1, 0, 1);
      push(0, 0, 0, 0,        0, 1, 0, 0);
      kick(1);
      run_sb("runB", 14, 2, 4, -1);

      // Full store without cfg_last: load must end on the DEPTH-th word.
      io.din_N = 32'h33;
      for (int k = 0; k < 16; k++) send(mk(9, 0, 7, 0, 0, 0, 0, 1), 1'b0, 0);
      chk("full.busy",      32'(io.busy), 0);
      chk("full.cfg_ready", 32'(io.cfg_ready), 1);
      push(0, 0, 0, 0, 0, 1, 1, 0);
      for (int k = 1; k < 16; k++) push(0, 0, 0, 32'h33, k, 1, 1, 0);
      push(0, 0, 0, 32'h33, 0, 1, 1, 0);
      push(0, 0, 0, 0, 0, 1, 0, 1);
      kick(1);
      run_sb("runC", 18, 100, 0, -1);

      // Next load restarts at entry 0.
      io.din_W = 32'h44;
      send(mk(9, 2, 7, 0, 1, 0, 0, 0), 1'b1, 0);
      push(0, 0, 0, 0, 0, 1, 1, 0);
      push(32'h44, 0, 0, 0, 0, 1, 1, 0);
      push(0, 0, 0, 0, 0, 1, 0, 1);
      push(0, 0, 0, 0, 0, 1, 0, 0);
      kick(1);
      run_sb("runD", 4, 100, 0, -1);

      // iter=0 runs until abort.
      io.din_N = 32'hA; io.din_S = 32'hB;
      send(mk(9, 0, 7, 0, 1, 0, 0, 0), 1'b0, 0);
      send(mk(9, 1, 7, 0, 0, 1, 0, 0), 1'b1, 0);
      push(0, 0, 0, 0, 0, 1, 1, 0);
      for (int k = 1; k <= 40; k++) begin
         if (k % 2 == 1) push(32'hA, 0, 0, 0, 1, 1, 1, 0);
         else            push(0, 32'hB, 0, 0, 0, 1, 1, 0);
      end
      push(0, 0, 0, 0, 0, 0, 0, 1);
      push(0, 0, 0, 0, 0, 0, 0, 0);
      kick(0);
      run_sb("runE", 43, 100, 0, 40);
      chk("abort.cfg_ready", 32'(io.cfg_ready), 1);

      // Reset in the middle of a run clears len, so a later start is ignored.
      push(0, 0, 0, 0, 0, 1, 1, 0);
      push(32'hA, 0, 0, 0, 1, 1, 1, 0);
      push(0, 32'hB, 0, 0, 0, 1, 1, 0);
      kick(0);
      run_sb("runF", 3, 100, 0, -1);
      rst = 1'b1;
      step();
      chk("midrst.busy",    32'(io.busy), 0);
      chk("midrst.done",    32'(io.done), 0);
      chk("midrst.ctx_ptr", 32'(io.ctx_ptr), 0);
      chk("midrst.dout_N",  io.dout_N, 0);
      chk("midrst.dout_S",  io.dout_S, 0);
      rst = 1'b0;
      kick(0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("nolen.busy.c%0d", k), 32'(io.busy), 0);
         chk($sformatf("nolen.done.c%0d", k), 32'(io.done), 0);
         chk($sformatf("nolen.dout_N.c%0d", k), io.dout_N, 0);
         step();
      end

      chk("sb.drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pe_ctx_seq.md
Name: pe_ctx_seq

Overview:
- Parametrised CGRA processing element with a multi-context configuration store.
- Contexts are loaded over a valid/ready stream. After a start pulse, the block replays them cyclically for a programmed number of iterations.
- Per context: two operands are selected from the 4 neighbour inputs, the result register or two local registers; one ALU op runs; each output port is routed independently.
- Successor to the fixed-width single-pass PE, adding width/depth parameters, S port, handshake load, looping, stall and abort.

Parameters:
- DW, 32: datapath width; must be ≥8.
- DEPTH, 16: context store entries; power of 2.
- ITW, 16: iteration-count width.
- INST_W, 20: instruction width; fixed by the field layout, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  context word valid
- cfg_ready  out  1  store accepts word
- cfg_data  in  INST_W  context word
- cfg_last  in  1  final word of program
- start  in  1  one-cycle run request
- iter  in  ITW  passes over program; 0 = run until abort
- abort  in  1  stop run
- stall  in  1  freeze execution
- din_N/din_S/din_W/din_E  in  DW  neighbour inputs
- dout_N/dout_S/dout_W/dout_E  out  DW  neighbour outputs
- busy  out  1  LOAD or RUN
- done  out  1  one-cycle completion pulse
- ctx_ptr  out  log2(DEPTH)  context being fetched

Behaviour:
Instruction layout, MSB→LSB:
- op[19:16]: 0 NOP (result 0), 1 ADD, 2 SUB (a−b), 3 MUL (low DW bits), 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR logical, 9 PASS_A, 10–15 NOP. Shift amount is b[log2(DW)-1:0]. All arithmetic is mod 2^DW, unsigned.
- sel_a[15:13], sel_b[12:10]: 0 N, 1 S, 2 W, 3 E, 4 res, 5 R0, 6 R1, 7 zero.
- wr[9:8]: bit0 writes fu result to R0, bit1 writes it to R1, same edge as res.
- osel_N[7:6], osel_S[5:4], osel_W[3:2], osel_E[1:0]: 0 zero, 1 res, 2 opposite input (N←S, S←N, W←E, E←W), 3 R0.

FSM:
- IDLE → LOAD on first accepted cfg word.
- LOAD → IDLE on the word with cfg_last, or on the DEPTH-th word; either way len = words accepted.
- IDLE → RUN on start when len≠0.
- RUN → DONE when the last context of the last iteration has been fetched and executed, or on abort.
- DONE → IDLE after 1 cycle with done=1.

Load:
- cfg_ready=1 only in IDLE/LOAD.
- A word is accepted when cfg_valid&cfg_ready and written to store[wptr]; wptr increments.
- A new load from IDLE restarts wptr at 0.

Run pipeline:
- Cycle t: inst_r <= store[ptr]; ptr increments and wraps len-1→0; each wrap increments the pass count.
- Cycle t+1: the fu executes inst_r combinationally; dout uses inst_r.
- Edge ending t+1: res/R0/R1 update.
- Latency fetch→res visible is 2 cycles.
- Run ends after the pass count reaches iter and the final inst_r has executed (one drain cycle).

Other rules:
- stall=1: ptr, pass count, inst_r, res, R0, R1 and FSM hold; outputs stay stable. abort overrides stall.
- Outside RUN: inst_r=0 (NOP, all outputs 0); res/R0/R1 hold their values.
- start during LOAD/RUN/DONE is ignored. start with len=0 is ignored (no done).
- cfg and start in the same IDLE cycle: the cfg word is taken and start is ignored.
- Reset at any time: FSM IDLE, len/wptr/ptr/pass count 0, inst_r/res/R0/R1 0, all douts 0, done 0, busy 0. Store contents need not be cleared.

Decomposition:
- Shared package: opcode constants, sel/osel encodings, field offsets, INST_W.
- Sub-module pe_alu: combinational, DW-parametrised; op, a, b → result.
- The FSM, store, operand/output muxes and registers live in the top module.

Test Plan:
- Load 3 words (last on 3rd, with cfg_valid gaps): len=3, cfg_ready=1 throughout. Then start with iter=2, din_N=5, din_W=7, ctx0=ADD N,W,wr=01,osel_E=1: res=12 two cycles after ptr=0 fetch; dout_E=12 while ctx0 executes on pass 2; done after 6 fetches plus 1 drain cycle.
- SUB with a=0, b=1 (DW=32): res=0xFFFFFFFF. SHL with a=1, b=35: res=8. MUL 0x10000×0x10000: res=0.
- Load DEPTH words with cfg_last=0: LOAD exits, len=DEPTH. The next word restarts at index 0.
- Hold stall for 4 cycles mid-run: ctx_ptr, res and douts are unchanged. Completion is delayed exactly 4 cycles.
- iter=0: ptr wraps indefinitely. Assert abort: done pulses next cycle, then IDLE with busy=0 and dout=0.
- Assert rst mid-RUN: all outputs 0 on the next cycle. A subsequent start without reload runs the old program only if len was kept, which it is not (len=0, so start is ignored).
